// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: Hall code constants, 6-step sequence helpers and
// the speed word width shared with the downstream subtractor.
package bldc_pkg;

  localparam int SPD_W = 9;

  typedef logic [2:0] hall_t;

  localparam hall_t H_101 = 3'b101;
  localparam hall_t H_100 = 3'b100;
  localparam hall_t H_110 = 3'b110;
  localparam hall_t H_010 = 3'b010;
  localparam hall_t H_011 = 3'b011;
  localparam hall_t H_001 = 3'b001;

  // Forward order: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101.
  // Illegal inputs map to 000, which can never match a legal code.
  function automatic hall_t hall_next_fwd(input hall_t code);
    hall_t nxt;
    case (code)
      H_101:   nxt = H_100;
      H_100:   nxt = H_110;
      H_110:   nxt = H_010;
      H_010:   nxt = H_011;
      H_011:   nxt = H_001;
      H_001:   nxt = H_101;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  function automatic hall_t hall_next_rev(input hall_t code);
    hall_t nxt;
    case (code)
      H_101:   nxt = H_001;
      H_001:   nxt = H_011;
      H_011:   nxt = H_010;
      H_010:   nxt = H_110;
      H_110:   nxt = H_100;
      H_100:   nxt = H_101;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  function automatic logic hall_legal(input hall_t code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

endpackage

// File: rtl/hall_sync_edge.sv
// Hall input synchroniser, previous-code register and transition classifier.
// Outputs are single-cycle flags for the transition seen in the current cycle.
module hall_sync_edge
  import bldc_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  hall_t hall,
  output logic  edge_fwd,
  output logic  edge_rev,
  output logic  bad_code,
  output logic  bad_jump
);

  hall_t sync1_reg;
  hall_t sync2_reg;
  hall_t prev_reg;
  logic  primed_reg;

  // Pure data path; no reset needed on the synchroniser flops.
  always_ff @(posedge clk) begin
    sync1_reg <= hall;
    sync2_reg <= sync1_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_reg   <= '0;
      primed_reg <= 1'b0;
    end else if (!en) begin
      primed_reg <= 1'b0;
    end else begin
      prev_reg   <= sync2_reg;
      primed_reg <= 1'b1;
    end
  end

  // A step away from an illegal previous code is neither counted nor flagged.
  always_comb begin
    edge_fwd = 1'b0;
    edge_rev = 1'b0;
    bad_code = 1'b0;
    bad_jump = 1'b0;
    if (en && primed_reg && (sync2_reg != prev_reg)) begin
      if (!hall_legal(sync2_reg)) begin
        bad_code = 1'b1;
      end else if (hall_legal(prev_reg)) begin
        if (sync2_reg == hall_next_fwd(prev_reg)) begin
          edge_fwd = 1'b1;
        end else if (sync2_reg == hall_next_rev(prev_reg)) begin
          edge_rev = 1'b1;
        end else begin
          bad_jump = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hall_speed_meter.sv
// Hall-sensor speed meter: counts valid commutation steps per gate window and
// presents a saturated speed word, direction and sticky fault flag.
module hall_speed_meter #(
  parameter int GATE_CYCLES = 50000,
  parameter int SPD_W       = bldc_pkg::SPD_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  bldc_pkg::hall_t     HALL,
  output logic [SPD_W-1:0]    SPEED,
  output logic                SPEED_VALID,
  output logic                DIR,
  output logic                SAT,
  output logic                HALL_FAULT
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int EW = SPD_W + 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [EW-1:0] ECNT_MAX  = '1;
  localparam logic [EW:0]   SPD_MAX   = (EW + 1)'((1 << SPD_W) - 1);

  logic edge_fwd;
  logic edge_rev;
  logic bad_code;
  logic bad_jump;

  hall_sync_edge u_sync_edge (
    .clk      (CLK),
    .rst_n    (RST_N),
    .en       (EN),
    .hall     (HALL),
    .edge_fwd (edge_fwd),
    .edge_rev (edge_rev),
    .bad_code (bad_code),
    .bad_jump (bad_jump)
  );

  logic [GW-1:0]    gate_reg;
  logic [EW-1:0]    edge_cnt_reg;
  logic [EW-1:0]    edge_cnt_next;
  logic [SPD_W-1:0] speed_reg;
  logic             valid_reg;
  logic             dir_reg;
  logic             sat_reg;
  logic             fault_reg;
  logic             edge_now;
  logic             terminal;
  logic [EW:0]      total;

  // total includes a step landing on the terminal cycle, so it closes with its window.
  always_comb begin
    edge_now      = edge_fwd | edge_rev;
    terminal      = (gate_reg == GATE_LAST);
    total         = {1'b0, edge_cnt_reg} + (EW + 1)'(edge_now);
    edge_cnt_next = (edge_cnt_reg == ECNT_MAX) ? edge_cnt_reg : total[EW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      gate_reg     <= '0;
      edge_cnt_reg <= '0;
      speed_reg    <= '0;
      valid_reg    <= 1'b0;
      dir_reg      <= 1'b1;
      sat_reg      <= 1'b0;
      fault_reg    <= 1'b0;
    end else if (!EN) begin
      gate_reg     <= '0;
      edge_cnt_reg <= '0;
      valid_reg    <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      fault_reg <= fault_reg | bad_code | bad_jump;
      if (edge_fwd) begin
        dir_reg <= 1'b1;
      end else if (edge_rev) begin
        dir_reg <= 1'b0;
      end
      if (terminal) begin
        gate_reg     <= '0;
        edge_cnt_reg <= '0;
        valid_reg    <= 1'b1;
        if (total > SPD_MAX) begin
          speed_reg <= '1;
          sat_reg   <= 1'b1;
        end else begin
          speed_reg <= total[SPD_W-1:0];
          sat_reg   <= 1'b0;
        end
      end else begin
        gate_reg     <= gate_reg + GW'(1);
        edge_cnt_reg <= edge_cnt_next;
        valid_reg    <= 1'b0;
      end
    end
  end

  assign SPEED       = speed_reg;
  assign SPEED_VALID = valid_reg;
  assign DIR         = dir_reg;
  assign SAT         = sat_reg;
  assign HALL_FAULT  = fault_reg;

endmodule
